// File: rtl/memory_ctl.sv
// memory_ctl: memory-stage control and MEM/WB pipeline register.
// Issues load/store requests on a req/ack data-memory port, formats load
// data, and stalls upstream stages while an access is outstanding.
module memory_ctl #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_out,
  input  logic [31:0] data_b_exe,
  input  logic [31:0] pc_exe,
  input  logic [31:0] instr_exe,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  output logic        mem_stall,
  output logic [31:0] wb_data,
  output logic [4:0]  rd_mem,
  output logic        reg_wen,
  output logic [31:0] pc_mem,
  output logic [31:0] instr_mem,
  output logic        misalign,
  output logic        bus_err
);

  localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]  OPC_STORE = 7'b0100011;
  localparam logic [6:0]  OPC_LUI   = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC = 7'b0010111;
  localparam logic [6:0]  OPC_JAL   = 7'b1101111;
  localparam logic [6:0]  OPC_JALR  = 7'b1100111;
  localparam logic [6:0]  OPC_OPIMM = 7'b0010011;
  localparam logic [6:0]  OPC_OP    = 7'b0110011;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  // Last WAIT-cycle count value before the access is abandoned.
  localparam logic [7:0]  CNT_LAST  = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state_r;
  logic [7:0]  cnt_r;

  logic [6:0]  opcode_s;
  logic [2:0]  f3_s;
  logic [1:0]  lane_s;
  logic [4:0]  rd_s;
  logic        is_load_s;
  logic        is_store_s;
  logic        legal_ls_s;
  logic        misal_raw_s;
  logic        mis_s;
  logic        mem_op_s;
  logic        wen_op_s;
  logic        wen_pass_s;
  logic        wen_ack_s;
  logic        timeout_s;
  logic [31:0] wb_pass_s;
  logic [31:0] wb_ack_s;

  // Byte enables for an access of the given size at the given byte lane.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   lane_be = 4'b0001 << lane;
      2'b01:   lane_be = lane[1] ? 4'b1100 : 4'b0011;
      2'b10:   lane_be = 4'b1111;
      default: lane_be = 4'b0000;
    endcase
  endfunction

  // Store data replicated across every lane it may land in.
  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] rs2);
    case (size)
      2'b00:   store_wdata = {4{rs2[7:0]}};
      2'b01:   store_wdata = {2{rs2[15:0]}};
      2'b10:   store_wdata = rs2;
      default: store_wdata = 32'h0000_0000;
    endcase
  endfunction

  // Extract the addressed byte/half from the read word and extend it.
  function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {lane, 3'b000};
    case (f3)
      3'b000:  format_load = {{24{sh[7]}}, sh[7:0]};
      3'b001:  format_load = {{16{sh[15]}}, sh[15:0]};
      3'b010:  format_load = rdata;
      3'b100:  format_load = {24'h00_0000, sh[7:0]};
      3'b101:  format_load = {16'h0000, sh[15:0]};
      default: format_load = 32'h0000_0000;
    endcase
  endfunction

  // Instruction decode, alignment check and writeback value selection.
  always_comb begin
    opcode_s   = instr_exe[6:0];
    f3_s       = instr_exe[14:12];
    lane_s     = alu_out[1:0];
    rd_s       = instr_exe[11:7];
    is_load_s  = (opcode_s == OPC_LOAD);
    is_store_s = (opcode_s == OPC_STORE);
    case (f3_s)
      3'b000, 3'b001, 3'b010: legal_ls_s = is_load_s || is_store_s;
      3'b100, 3'b101:         legal_ls_s = is_load_s;
      default:                legal_ls_s = 1'b0;
    endcase
    case (f3_s[1:0])
      2'b01:   misal_raw_s = lane_s[0];
      2'b10:   misal_raw_s = (lane_s != 2'b00);
      default: misal_raw_s = 1'b0;
    endcase
    mis_s    = legal_ls_s && misal_raw_s;
    mem_op_s = legal_ls_s && !misal_raw_s;
    case (opcode_s)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_OPIMM, OPC_OP, OPC_LOAD: wen_op_s = 1'b1;
      default:                     wen_op_s = 1'b0;
    endcase
    // Loads only retire through the ack path; here they are misaligned or illegal.
    wen_pass_s = wen_op_s && (rd_s != 5'd0) && !is_load_s;
    wen_ack_s  = is_load_s && (rd_s != 5'd0);
    wb_pass_s  = ((opcode_s == OPC_JAL) || (opcode_s == OPC_JALR)) ? (pc_exe + 32'd4) : alu_out;
    wb_ack_s   = is_load_s ? format_load(f3_s, lane_s, dmem_rdata) : alu_out;
    timeout_s  = (cnt_r == CNT_LAST);
  end

  // Upstream stall: held through the issue cycle and every un-acked WAIT cycle.
  always_comb begin
    mem_stall = 1'b0;
    if (rst) begin
      mem_stall = 1'b0;
    end else if (state_r == IDLE) begin
      mem_stall = mem_op_s;
    end else begin
      mem_stall = !dmem_ack && !timeout_s;
    end
  end

  // Access FSM, memory request registers and MEM/WB pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 8'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0000_0000;
      dmem_be    <= 4'b0000;
      dmem_wdata <= 32'h0000_0000;
      instr_mem  <= NOP_INSTR;
      pc_mem     <= 32'h0000_0000;
      wb_data    <= 32'h0000_0000;
      rd_mem     <= 5'd0;
      reg_wen    <= 1'b0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (mem_op_s) begin
            state_r    <= WAIT;
            cnt_r      <= 8'd0;
            dmem_req   <= 1'b1;
            dmem_we    <= is_store_s;
            dmem_addr  <= {alu_out[31:2], 2'b00};
            dmem_be    <= lane_be(f3_s[1:0], lane_s);
            dmem_wdata <= is_store_s ? store_wdata(f3_s[1:0], data_b_exe) : 32'h0000_0000;
            instr_mem  <= NOP_INSTR;
            pc_mem     <= 32'h0000_0000;
            wb_data    <= 32'h0000_0000;
            rd_mem     <= 5'd0;
            reg_wen    <= 1'b0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
          end else begin
            instr_mem  <= instr_exe;
            pc_mem     <= pc_exe;
            wb_data    <= wb_pass_s;
            rd_mem     <= rd_s;
            reg_wen    <= wen_pass_s && !mis_s;
            misalign   <= mis_s;
            bus_err    <= 1'b0;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            state_r    <= IDLE;
            dmem_req   <= 1'b0;
            instr_mem  <= instr_exe;
            pc_mem     <= pc_exe;
            wb_data    <= wb_ack_s;
            rd_mem     <= rd_s;
            reg_wen    <= wen_ack_s;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
          end else if (timeout_s) begin
            state_r    <= IDLE;
            dmem_req   <= 1'b0;
            instr_mem  <= instr_exe;
            pc_mem     <= pc_exe;
            wb_data    <= alu_out;
            rd_mem     <= rd_s;
            reg_wen    <= 1'b0;
            misalign   <= 1'b0;
            bus_err    <= 1'b1;
          end else begin
            cnt_r      <= cnt_r + 8'd1;
          end
        end
        default: begin
          state_r    <= IDLE;
          dmem_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_ctl.sv
// tb_memory_ctl: directed scoreboard bench for memory_ctl (ACK_TIMEOUT=4).
module tb_memory_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_out, data_b_exe, pc_exe, instr_exe, dmem_rdata;
  logic        dmem_ack;
  logic        dmem_req, dmem_we, mem_stall, reg_wen, misalign, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, wb_data, pc_mem, instr_mem;
  logic [3:0]  dmem_be;
  logic [4:0]  rd_mem;

  always #5 clk = ~clk;

  memory_ctl #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .alu_out(alu_out), .data_b_exe(data_b_exe),
    .pc_exe(pc_exe), .instr_exe(instr_exe), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .mem_stall(mem_stall), .wb_data(wb_data), .rd_mem(rd_mem),
    .reg_wen(reg_wen), .pc_mem(pc_mem), .instr_mem(instr_mem),
    .misalign(misalign), .bus_err(bus_err)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] wb;
    logic [4:0]  rd;
    logic        wen;
    logic        mis;
    logic        berr;
    logic        chk_ctx;
    logic        chk_wb;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] rs2);
    instr_exe  = instr;
    pc_exe     = pc;
    alu_out    = alu;
    data_b_exe = rs2;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] wb,
                          input logic [4:0] rd, input logic wen, input logic mis, input logic berr,
                          input logic chk_ctx, input logic chk_wb);
    exp_t e;
    e.pc = pc; e.instr = instr; e.wb = wb; e.rd = rd; e.wen = wen;
    e.mis = mis; e.berr = berr; e.chk_ctx = chk_ctx; e.chk_wb = chk_wb;
    sb_q.push_back(e);
  endtask

  task automatic push_bubble();
    push_exp(32'h0, 32'h0000_0013, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  // Pop the oldest expectation and compare it with the pipeline register.
  task automatic pop_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_wen"}, {31'd0, reg_wen}, {31'd0, e.wen});
      chk({tag, "_mis"}, {31'd0, misalign}, {31'd0, e.mis});
      chk({tag, "_berr"}, {31'd0, bus_err}, {31'd0, e.berr});
      if (e.chk_ctx) begin
        chk({tag, "_pc"}, pc_mem, e.pc);
        chk({tag, "_instr"}, instr_mem, e.instr);
        chk({tag, "_rd"}, {27'd0, rd_mem}, {27'd0, e.rd});
      end else begin
        checks = checks;
      end
      if (e.chk_wb) begin
        chk({tag, "_wb"}, wb_data, e.wb);
      end else begin
        checks = checks;
      end
    end
  endtask

  // Run one presented instruction until the stall drops; ack_at < 0 means never ack.
  task automatic mem_access(input string tag, input int ack_at, input logic [31:0] rdata,
                            output int stalls, output int reqs, output logic we,
                            output logic [31:0] addr, output logic [3:0] be,
                            output logic [31:0] wdata);
    logic done;
    done = 1'b0; stalls = 0; reqs = 0; we = 1'b0;
    addr = 32'h0; be = 4'h0; wdata = 32'h0;
    for (int c = 0; c < 16 && !done; c++) begin
      if (c == ack_at) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
      end
      #1;
      if (dmem_req === 1'b1) begin
        if (reqs == 0) begin
          we = dmem_we; addr = dmem_addr; be = dmem_be; wdata = dmem_wdata;
        end
        reqs++;
      end
      if (mem_stall === 1'b1) stalls++;
      else done = 1'b1;
      tick();
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int          st, rq;
    logic        we;
    logic [31:0] ad, wd;
    logic [3:0]  be;

    // Reset with an aligned load presented: stall must stay low.
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    drive(32'h0000_2383, 32'h10, 32'h104, 32'h0);
    #1;
    chk("stall_in_rst", {31'd0, mem_stall}, 32'd0);
    tick();
    chk("stall_in_rst2", {31'd0, mem_stall}, 32'd0);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_be", {28'd0, dmem_be}, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    push_bubble();
    pop_check("rst");
    rst = 1'b0;

    // ADDI x5, 10
    drive(32'h00A0_0293, 32'h40, 32'h0000_000A, 32'h0);
    push_exp(32'h40, 32'h00A0_0293, 32'h0000_000A, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    mem_access("addi", -1, 32'h0, st, rq, we, ad, be, wd);
    chk("addi_stall", st, 32'd0);
    chk("addi_req", rq, 32'd0);
    pop_check("addi");

    // ADDI x0: no register write
    drive(32'h00A0_0013, 32'h44, 32'h0000_000A, 32'h0);
    push_exp(32'h44, 32'h00A0_0013, 32'h0000_000A, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    mem_access("addi_x0", -1, 32'h0, st, rq, we, ad, be, wd);
    pop_check("addi_x0");

    // JAL x1: link value pc+4
    drive(32'h0000_00EF, 32'h80, 32'h1234_5678, 32'h0);
    push_exp(32'h80, 32'h0000_00EF, 32'h84, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    mem_access("jal", -1, 32'h0, st, rq, we, ad, be, wd);
    pop_check("jal");

    // JALR x1 at top of address space: pc+4 wraps to 0
    drive(32'h0000_80E7, 32'hFFFF_FFFC, 32'h5555_0000, 32'h0);
    push_exp(32'hFFFF_FFFC, 32'h0000_80E7, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    mem_access("jalr", -1, 32'h0, st, rq, we, ad, be, wd);
    pop_check("jalr");

    // LB x6 at 0x103, ack in third WAIT-adjacent cycle
    drive(32'h0000_0303, 32'h100, 32'h103, 32'h0);
    push_exp(32'h100, 32'h0000_0303, 32'hFFFF_FF80, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    mem_access("lb", 3, 32'h8011_2233, st, rq, we, ad, be, wd);
    chk("lb_stall", st, 32'd3);
    chk("lb_req", rq, 32'd3);
    chk("lb_addr", ad, 32'h100);
    chk("lb_be", {28'd0, be}, 32'h8);
    chk("lb_we", {31'd0, we}, 32'd0);
    chk("lb_req_drop", {31'd0, dmem_req}, 32'd0);
    pop_check("lb");

    // LBU same address, minimum occupancy
    drive(32'h0000_4303, 32'h104, 32'h103, 32'h0);
    push_exp(32'h104, 32'h0000_4303, 32'h0000_0080, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    mem_access("lbu", 1, 32'h8011_2233, st, rq, we, ad, be, wd);
    chk("lbu_stall", st, 32'd1);
    pop_check("lbu");

    // LH upper half
    drive(32'h0000_1303, 32'h108, 32'h102, 32'h0);
    push_exp(32'h108, 32'h0000_1303, 32'hFFFF_8011, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    mem_access("lh", 2, 32'h8011_2233, st, rq, we, ad, be, wd);
    chk("lh_be", {28'd0, be}, 32'hC);
    pop_check("lh");

    // SH at 0x202
    drive(32'h0000_1023, 32'h200, 32'h202, 32'h1234_ABCD);
    push_exp(32'h200, 32'h0000_1023, 32'h202, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    mem_access("sh", 1, 32'h0, st, rq, we, ad, be, wd);
    chk("sh_we", {31'd0, we}, 32'd1);
    chk("sh_be", {28'd0, be}, 32'hC);
    chk("sh_wdata", wd, 32'hABCD_ABCD);
    chk("sh_addr", ad, 32'h200);
    pop_check("sh");

    // SB at 0x301
    drive(32'h0000_0023, 32'h204, 32'h301, 32'h0000_00A5);
    push_exp(32'h204, 32'h0000_0023, 32'h301, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    mem_access("sb", 2, 32'h0, st, rq, we, ad, be, wd);
    chk("sb_be", {28'd0, be}, 32'h2);
    chk("sb_wdata", wd, 32'hA5A5_A5A5);
    pop_check("sb");

    // Misaligned LW x7 at 0x101
    drive(32'h0000_2383, 32'h300, 32'h101, 32'h0);
    push_exp(32'h300, 32'h0000_2383, 32'h0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    mem_access("lw_mis", -1, 32'h0, st, rq, we, ad, be, wd);
    chk("lw_mis_stall", st, 32'd0);
    chk("lw_mis_req", rq, 32'd0);
    pop_check("lw_mis");

    // Illegal load funct3 011
    drive(32'h0000_3383, 32'h304, 32'h108, 32'h0);
    push_exp(32'h304, 32'h0000_3383, 32'h0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    mem_access("ill", -1, 32'h0, st, rq, we, ad, be, wd);
    chk("ill_req", rq, 32'd0);
    pop_check("ill");

    // SW never acked: timeout after 4 request cycles
    drive(32'h0000_2023, 32'h400, 32'h400, 32'hCAFE_F00D);
    push_exp(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    mem_access("sw_to", -1, 32'h0, st, rq, we, ad, be, wd);
    chk("sw_to_req", rq, 32'd4);
    chk("sw_to_stall", st, 32'd4);
    chk("sw_to_be", {28'd0, be}, 32'hF);
    chk("sw_to_wdata", wd, 32'hCAFE_F00D);
    chk("sw_to_req_drop", {31'd0, dmem_req}, 32'd0);
    pop_check("sw_to");

    // LW acked in the timeout cycle: ack wins
    drive(32'h0000_2383, 32'h500, 32'h104, 32'h0);
    push_exp(32'h500, 32'h0000_2383, 32'hDEAD_BEEF, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    mem_access("lw_race", 4, 32'hDEAD_BEEF, st, rq, we, ad, be, wd);
    chk("lw_race_req", rq, 32'd4);
    pop_check("lw_race");

    // Reset in the second WAIT cycle of an LW, then a late ack
    drive(32'h0000_2383, 32'h600, 32'h108, 32'h0);
    #1;
    chk("rstw_stall0", {31'd0, mem_stall}, 32'd1);
    tick();
    chk("rstw_req1", {31'd0, dmem_req}, 32'd1);
    tick();
    rst = 1'b1;
    #1;
    chk("rstw_stall_rst", {31'd0, mem_stall}, 32'd0);
    tick();
    rst = 1'b0;
    chk("rstw_req_drop", {31'd0, dmem_req}, 32'd0);
    push_bubble();
    pop_check("rstw");
    drive(32'h00A0_0293, 32'h700, 32'h0000_0077, 32'h0);
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    push_exp(32'h700, 32'h00A0_0293, 32'h0000_0077, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    chk("late_ack_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    dmem_ack = 1'b0;
    chk("late_ack_req", {31'd0, dmem_req}, 32'd0);
    pop_check("late_ack");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_ctl.md
# memory_ctl

Memory-stage control and pipeline register sitting directly downstream of the execute stage. Consumes the execute-stage instruction, PC, ALU result and rs2 data, and runs load/store accesses over a request/acknowledge data-memory port. It aligns load data and extends its sign, and presents a registered writeback bundle to the writeback stage. While an access is outstanding it raises a stall that freezes all upstream stages.

## Interface
- ACK_TIMEOUT, 255: number of WAIT cycles without `dmem_ack` before the access is aborted with `bus_err`; legal range 1–255.
- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- alu_out  in  32  execute ALU result; the effective address for loads/stores
- data_b_exe  in  32  rs2 value; store data
- pc_exe  in  32  execute-stage PC
- instr_exe  in  32  execute-stage instruction
- dmem_ack  in  1  memory completes the current request
- dmem_rdata  in  32  read word; valid only when `dmem_ack`=1
- dmem_req  out  1  access request, registered
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  32  word address, `{alu_out[31:2],2'b00}`
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- mem_stall  out  1  hold upstream stages; combinational
- wb_data  out  32  writeback value
- rd_mem  out  5  destination register, `instr[11:7]`
- reg_wen  out  1  register-file write enable
- pc_mem  out  32  registered PC
- instr_mem  out  32  registered instruction
- misalign  out  1  misaligned load/store, registered
- bus_err  out  1  access timed out, registered

## Operation
- Classification uses opcode `instr_exe[6:0]`.
  - LOAD 0000011 with funct3 000/001/010/100/101 (LB/LH/LW/LBU/LHU).
  - STORE 0100011 with funct3 000/001/010 (SB/SH/SW).
  - Any other funct3 under LOAD/STORE is illegal: pass through with `reg_wen`=0 and no request.
- Alignment rules: H needs `addr[0]`=0; W needs `addr[1:0]`=0. A misaligned access issues no request and passes in 1 cycle with `misalign`=1 and `reg_wen`=0.
- FSM has two states, IDLE and WAIT.
  - IDLE with an aligned, legal memory op:
    - `mem_stall`=1 in that cycle.
    - On the edge: register `dmem_req`=1 and addr/we/be/wdata, clear the timeout counter, go to WAIT.
    - The pipeline register is loaded with a bubble.
  - IDLE with any other instruction: no stall; the pipeline register is loaded from the inputs.
  - WAIT:
    - `mem_stall` = !`dmem_ack`.
    - Request fields stay stable and the counter increments every cycle.
  - WAIT with `dmem_ack`=1:
    - Capture the formatted result into the pipeline register.
    - Drop `dmem_req` and return to IDLE.
  - WAIT with counter = ACK_TIMEOUT-1 and no ack:
    - `mem_stall`=0 in that cycle.
    - Drop `dmem_req`; load the pipeline register with `bus_err`=1 and `reg_wen`=0; return to IDLE.
  - WAIT with ack and timeout in the same cycle: ack wins.
- Store lanes:
  - SB: `be = 1<<addr[1:0]`, `wdata = {4{rs2[7:0]}}`.
  - SH: `be = addr[1] ? 1100 : 0011`, `wdata = {2{rs2[15:0]}}`.
  - SW: `be = 1111`, `wdata = rs2`.
- Loads:
  - `be` is set by size, using the same rules as stores.
  - The selected byte or half is extracted from the `addr[1:0]` lane.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- `wb_data` select:
  - JAL (1101111) and JALR (1100111): `pc_exe+4`, mod 2^32.
  - LOAD: the formatted read data.
  - All others: `alu_out`.
- `reg_wen`=1 only when all of these hold:
  - opcode is LUI, AUIPC, JAL, JALR, OP-IMM, OP, or LOAD;
  - rd ≠ 0;
  - no misalign and no bus_err.
- Bubble contents: `instr_mem`=32'h00000013, `pc_mem`=0, `wb_data`=0, `rd_mem`=0, `reg_wen`=0, flags=0.
- `dmem_ack` in IDLE is ignored; `dmem_rdata` is sampled only on ack.

## Timing
- Reset (synchronous, `rst`=1 at an edge):
  - `dmem_req`/`dmem_we`=0; `dmem_addr`/`dmem_be`/`dmem_wdata`=0.
  - Pipeline register = bubble; state IDLE; counter 0.
  - `mem_stall` is 0 while `rst` is high.
  - `rst` during WAIT aborts the access: `dmem_req` falls at that edge and no writeback is produced.
- Non-memory, misaligned or illegal instruction: outputs valid 1 cycle after presentation.
- Memory op presented at cycle 0:
  - `dmem_req` is high from cycle 1.
  - An ack in cycle k≥1 makes the result visible in cycle k+1; `mem_stall` is high in cycles 0..k-1.
  - Minimum occupancy is 2 cycles.
- Upstream holds `instr_exe`, `alu_out` and `data_b_exe` stable while `mem_stall`=1.

## Test plan
- ADDI x5 (`instr_exe`=0x00A00293, `alu_out`=0xA), no stall → next cycle `reg_wen`=1, `rd_mem`=5, `wb_data`=0xA.
- LB at addr 0x103, ack after 3 wait cycles with `rdata`=0x80112233:
  - `dmem_addr`=0x100, `be`=1000.
  - `mem_stall` is high for 3 cycles.
  - `wb_data`=0xFFFFFF80.
  - LBU at the same address yields 0x00000080.
- SH at 0x202 with rs2=0x1234ABCD → `dmem_we`=1, `be`=1100, `wdata`=0xABCDABCD, `reg_wen`=0.
- LW at 0x101 → no `dmem_req`, no stall, `misalign`=1, `reg_wen`=0.
- ACK_TIMEOUT=4, SW with ack never asserted → `dmem_req` is high for 4 cycles, then `bus_err`=1 and the stall is released.
- `rst` in the second WAIT cycle of an LW → `dmem_req` is 0 next cycle, `instr_mem`=0x13, and a late ack has no effect.
